// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch defaults and the fetch FSM state encoding.
package cpu_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC_DEF   = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry valid/ready holding register between fetch and decode.
module fetch_buffer
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic            consume_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    // Flush beats load beats consume; data is only replaced on load so it stays stable otherwise.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, keeps at most one instruction-memory read in flight,
// and hands returned words to decode through a one-entry buffer.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] PC_INC   = PC_INC_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            if_ready
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] issued_pc_q, issued_pc_d;
    logic            buf_load, buf_flush, buf_free, issue;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        buf_load    = 1'b0;
        buf_flush   = 1'b0;
        buf_free    = !if_valid || if_ready;
        imem_req    = (state_q == REQ) && buf_free;
        issue       = imem_req && imem_gnt;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                // A read granted in the same cycle as a redirect is already stale.
                if (issue) begin
                    state_d     = redirect ? DROP : WAIT;
                    issued_pc_d = pc_q;
                    pc_d        = pc_q + PC_INC;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d  = REQ;
                    buf_load = !redirect;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase

        if (redirect && (state_q != IDLE)) begin
            pc_d      = redirect_pc & ~32'h3;
            buf_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            issued_pc_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
        end
    end

    assign imem_addr = pc_q;

    fetch_buffer u_fetch_buffer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (buf_load),
        .flush_i   (buf_flush),
        .consume_i (if_valid && if_ready),
        .instr_i   (imem_rdata),
        .pc_i      (issued_pc_q),
        .valid_o   (if_valid),
        .instr_o   (if_instr),
        .pc_o      (if_pc)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed per-cycle vector bench for instr_fetch_unit, plus an asynchronous reset sequence.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_ready    (if_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NV = 33;
    vec_t vecs[NV];

    function automatic vec_t mk(logic redir, logic [31:0] rpc, logic gnt, logic rv,
                                logic [31:0] rdata, logic rdy, logic e_req,
                                logic [31:0] e_addr, logic e_v, logic [31:0] e_pc,
                                logic [31:0] e_instr);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_v, input logic [31:0] e_pc, input logic [31:0] e_instr);
        chk({tag, ".imem_req"},  {31'd0, imem_req}, {31'd0, e_req});
        chk({tag, ".imem_addr"}, imem_addr, e_addr);
        chk({tag, ".if_valid"},  {31'd0, if_valid}, {31'd0, e_v});
        chk({tag, ".if_pc"},     if_pc, e_pc);
        chk({tag, ".if_instr"},  if_instr, e_instr);
    endtask

    initial begin
        // redir rpc gnt rv rdata rdy | req addr valid if_pc if_instr
        vecs[0]  = mk(0, 0, 0, 0, 0, 1,              0, 32'h0, 0, 32'h0, 32'h0);
        vecs[1]  = mk(0, 0, 1, 0, 0, 1,              1, 32'h0, 0, 32'h0, 32'h0);
        vecs[2]  = mk(0, 0, 0, 1, 32'hC0DE_0000, 1,  0, 32'h4, 0, 32'h0, 32'h0);
        vecs[3]  = mk(0, 0, 1, 0, 0, 1,              1, 32'h4, 1, 32'h0, 32'hC0DE_0000);
        vecs[4]  = mk(0, 0, 0, 1, 32'hC0DE_0004, 1,  0, 32'h8, 0, 32'h0, 32'hC0DE_0000);
        vecs[5]  = mk(0, 0, 1, 0, 0, 1,              1, 32'h8, 1, 32'h4, 32'hC0DE_0004);
        vecs[6]  = mk(0, 0, 0, 1, 32'hC0DE_0008, 1,  0, 32'hC, 0, 32'h4, 32'hC0DE_0004);
        vecs[7]  = mk(0, 0, 1, 0, 0, 1,              1, 32'hC, 1, 32'h8, 32'hC0DE_0008);
        vecs[8]  = mk(0, 0, 0, 1, 32'hC0DE_000C, 1,  0, 32'h10, 0, 32'h8, 32'hC0DE_0008);
        vecs[9]  = mk(0, 0, 1, 0, 0, 0,              0, 32'h10, 1, 32'hC, 32'hC0DE_000C);
        vecs[10] = mk(0, 0, 1, 0, 0, 0,              0, 32'h10, 1, 32'hC, 32'hC0DE_000C);
        vecs[11] = mk(0, 0, 0, 0, 0, 1,              1, 32'h10, 1, 32'hC, 32'hC0DE_000C);
        vecs[12] = mk(0, 0, 1, 0, 0, 1,              1, 32'h10, 0, 32'hC, 32'hC0DE_000C);
        vecs[13] = mk(1, 32'h0000_1003, 0, 0, 0, 1,  0, 32'h14, 0, 32'hC, 32'hC0DE_000C);
        vecs[14] = mk(0, 0, 0, 1, 32'hDEAD_0010, 1,  0, 32'h1000, 0, 32'hC, 32'hC0DE_000C);
        vecs[15] = mk(0, 0, 1, 0, 0, 1,              1, 32'h1000, 0, 32'hC, 32'hC0DE_000C);
        vecs[16] = mk(0, 0, 0, 1, 32'hE000_1000, 1,  0, 32'h1004, 0, 32'hC, 32'hC0DE_000C);
        vecs[17] = mk(0, 0, 0, 0, 0, 0,              0, 32'h1004, 1, 32'h1000, 32'hE000_1000);
        vecs[18] = mk(1, 32'h0000_2000, 1, 0, 0, 1,  1, 32'h1004, 1, 32'h1000, 32'hE000_1000);
        vecs[19] = mk(0, 0, 0, 1, 32'hDEAD_1004, 1,  0, 32'h2000, 0, 32'h1000, 32'hE000_1000);
        vecs[20] = mk(0, 0, 1, 0, 0, 1,              1, 32'h2000, 0, 32'h1000, 32'hE000_1000);
        vecs[21] = mk(0, 0, 0, 1, 32'hF000_2000, 1,  0, 32'h2004, 0, 32'h1000, 32'hE000_1000);
        vecs[22] = mk(1, 32'hFFFF_FFFE, 0, 0, 0, 0,  0, 32'h2004, 1, 32'h2000, 32'hF000_2000);
        vecs[23] = mk(0, 0, 1, 0, 0, 1,              1, 32'hFFFF_FFFC, 0, 32'h2000, 32'hF000_2000);
        vecs[24] = mk(0, 0, 0, 1, 32'hAB00_FFFC, 1,  0, 32'h0, 0, 32'h2000, 32'hF000_2000);
        vecs[25] = mk(0, 0, 0, 0, 0, 0,              0, 32'h0, 1, 32'hFFFF_FFFC, 32'hAB00_FFFC);
        vecs[26] = mk(1, 32'h0000_3000, 0, 0, 0, 1,  1, 32'h0, 1, 32'hFFFF_FFFC, 32'hAB00_FFFC);
        vecs[27] = mk(0, 0, 0, 1, 32'hBAD0_0000, 1,  1, 32'h3000, 0, 32'hFFFF_FFFC, 32'hAB00_FFFC);
        vecs[28] = mk(0, 0, 1, 0, 0, 1,              1, 32'h3000, 0, 32'hFFFF_FFFC, 32'hAB00_FFFC);
        vecs[29] = mk(0, 0, 0, 0, 0, 1,              0, 32'h3004, 0, 32'hFFFF_FFFC, 32'hAB00_FFFC);
        vecs[30] = mk(1, 32'h0000_4000, 0, 1, 32'hDEAD_3000, 1, 0, 32'h3004, 0, 32'hFFFF_FFFC, 32'hAB00_FFFC);
        vecs[31] = mk(0, 0, 0, 0, 0, 1,              1, 32'h4000, 0, 32'hFFFF_FFFC, 32'hAB00_FFFC);
        vecs[32] = mk(0, 0, 1, 0, 0, 1,              1, 32'h4000, 0, 32'hFFFF_FFFC, 32'hAB00_FFFC);

        reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 chk_all("reset", 0, 32'h0, 0, 32'h0, 32'h0);

        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            imem_gnt    = vecs[i].gnt;
            imem_rvalid = vecs[i].rv;
            imem_rdata  = vecs[i].rdata;
            if_ready    = vecs[i].rdy;
            #1 chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                       vecs[i].e_v, vecs[i].e_pc, vecs[i].e_instr);
            @(negedge clk);
        end

        // In WAIT with a response pending: reset must clear everything without a clock edge.
        redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
        #2 reset_n = 1'b0;
        #1 chk_all("async_rst", 0, 32'h0, 0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1 chk_all("rst_held", 0, 32'h0, 0, 32'h0, 32'h0);
        reset_n = 1'b1; imem_rvalid = 1'b0;
        #1 chk_all("post_rst_idle", 0, 32'h0, 0, 32'h0, 32'h0);
        @(negedge clk);
        imem_gnt = 1'b1; if_ready = 1'b1;
        #1 chk_all("post_rst_req", 1, 32'h0, 0, 32'h0, 32'h0);
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h7777_0000;
        #1 chk_all("post_rst_wait", 0, 32'h4, 0, 32'h0, 32'h0);
        @(negedge clk);
        imem_rvalid = 1'b0; if_ready = 1'b0;
        #1 chk_all("post_rst_data", 0, 32'h4, 1, 32'h0, 32'h7777_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
